// File: rtl/nipcb_pkg.sv
// Shared types and constants for the NIPCB scan scheduler.
package nipcb_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned GAIN_W = 3;

  localparam logic SPI_TGT_DAC = 1'b0;
  localparam logic SPI_TGT_ADC = 1'b1;

  localparam logic [15:0] ADC_CMD_BASE_DEF = 16'h8300;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DAC_START,
    ST_DAC_WAIT,
    ST_SELECT,
    ST_SETTLE,
    ST_ADC_START,
    ST_ADC_WAIT,
    ST_OUTPUT
  } state_e;

endpackage

// File: rtl/nipcb_next_ch.sv
// Priority rotator: next set bit of the mask strictly above the pointer, wrapping;
// a single-bit mask wraps all the way round and reselects the same channel.
module nipcb_next_ch
  import nipcb_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [CH_W-1:0]   o_idx,
  output logic [NUM_CH-1:0] o_onehot,
  output logic              o_found
);

  logic [CH_W-1:0] w_k;

  // Walk from the farthest candidate down so the nearest one wins.
  always_comb begin
    w_k      = i_ptr;
    o_idx    = i_ptr;
    o_found  = 1'b0;
    o_onehot = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_k = i_ptr + CH_W'(i);
      if (i_mask[w_k]) begin
        o_idx   = w_k;
        o_found = 1'b1;
      end
    end
    if (o_found) o_onehot = NUM_CH'(1) << o_idx;
  end

endmodule

// File: rtl/nipcb_scan_sched.sv
// Shares one SPI engine between host DAC writes and an autonomous ADC channel scan,
// driving the analog front-end controls and delivering tagged samples.
module nipcb_scan_sched
  import nipcb_pkg::*;
#(
  parameter logic [15:0] ADC_CMD_BASE = ADC_CMD_BASE_DEF,
  parameter int unsigned SPI_TIMEOUT  = 1024,
  parameter int unsigned SETTLE_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        chan_mask,
  input  logic [GAIN_W*NUM_CH-1:0] gain_cfg,
  input  logic [SETTLE_W-1:0]      settle_cycles,
  input  logic                     dac_req,
  input  logic [15:0]              dac_data,
  output logic                     dac_ack,
  output logic                     spi_start,
  output logic                     spi_target,
  output logic [15:0]              spi_wdata,
  input  logic                     spi_busy,
  input  logic                     spi_done,
  input  logic [15:0]              spi_rdata,
  output logic [NUM_CH-1:0]        ni_sel_ch,
  output logic [NUM_CH-1:0]        ni_en_ch,
  output logic [GAIN_W-1:0]        ni_pga_gain,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [15:0]              sample_data,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     spi_err
);

  localparam int unsigned TO_W = $clog2(SPI_TIMEOUT + 1);

  state_e              r_state, w_nxt_state;
  logic [CH_W-1:0]     r_ptr, w_nxt_ptr;
  logic [SETTLE_W-1:0] r_cnt, w_nxt_cnt;
  logic [TO_W-1:0]     r_to_cnt, w_nxt_to;
  logic                r_fair, w_nxt_fair;
  logic                r_spi_start, w_nxt_start;
  logic                r_spi_target, w_nxt_tgt;
  logic [15:0]         r_spi_wdata, w_nxt_wdata;
  logic                r_dac_ack, w_nxt_ack;
  logic [NUM_CH-1:0]   r_sel, w_nxt_sel;
  logic [NUM_CH-1:0]   r_en, w_nxt_en;
  logic [GAIN_W-1:0]   r_gain, w_nxt_gain;
  logic                r_valid, w_nxt_valid;
  logic [15:0]         r_sdata, w_nxt_sdata;
  logic [CH_W-1:0]     r_sch, w_nxt_sch;
  logic                r_err, w_nxt_err;

  logic [CH_W-1:0]     w_idx;
  logic [NUM_CH-1:0]   w_onehot;
  logic                w_found;
  logic                w_runnable;
  logic                w_to_hit;
  logic [GAIN_W-1:0]   w_gain_sel;

  nipcb_next_ch u_next_ch (
    .i_mask   (chan_mask),
    .i_ptr    (r_ptr),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_found  (w_found)
  );

  assign w_runnable = enable & w_found;
  assign w_to_hit   = (r_to_cnt == TO_W'(SPI_TIMEOUT - 1));

  always_comb begin
    w_gain_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_idx == CH_W'(k)) w_gain_sel = gain_cfg[GAIN_W*k +: GAIN_W];
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_to    = r_to_cnt;
    w_nxt_fair  = r_fair;
    w_nxt_start = 1'b0;
    w_nxt_tgt   = r_spi_target;
    w_nxt_wdata = r_spi_wdata;
    w_nxt_ack   = 1'b0;
    w_nxt_sel   = r_sel;
    w_nxt_en    = r_en;
    w_nxt_gain  = r_gain;
    w_nxt_valid = r_valid;
    w_nxt_sdata = r_sdata;
    w_nxt_sch   = r_sch;
    w_nxt_err   = r_err;
    unique case (r_state)
      ST_IDLE: begin
        if (dac_req && (!r_fair || !w_runnable)) w_nxt_state = ST_DAC_START;
        else if (w_runnable)                     w_nxt_state = ST_SELECT;
      end
      ST_DAC_START: begin
        if (!spi_busy) begin
          w_nxt_start = 1'b1;
          w_nxt_tgt   = SPI_TGT_DAC;
          w_nxt_wdata = dac_data;
          w_nxt_to    = '0;
          w_nxt_state = ST_DAC_WAIT;
        end
      end
      ST_DAC_WAIT: begin
        if (spi_done) begin
          w_nxt_ack   = 1'b1;
          w_nxt_fair  = 1'b1;
          w_nxt_state = ST_IDLE;
        end else if (w_to_hit) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_to = r_to_cnt + TO_W'(1);
        end
      end
      ST_SELECT: begin
        if (!w_runnable) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_ptr   = w_idx;
          w_nxt_sel   = w_onehot;
          w_nxt_en    = chan_mask;
          w_nxt_gain  = w_gain_sel;
          w_nxt_cnt   = settle_cycles;
          w_nxt_state = (settle_cycles == '0) ? ST_ADC_START : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_cnt = r_cnt - SETTLE_W'(1);
          if (r_cnt == SETTLE_W'(1)) w_nxt_state = ST_ADC_START;
        end
      end
      ST_ADC_START: begin
        if (!spi_busy) begin
          w_nxt_start = 1'b1;
          w_nxt_tgt   = SPI_TGT_ADC;
          w_nxt_wdata = ADC_CMD_BASE | {4'b0, r_ptr, 10'b0};
          w_nxt_to    = '0;
          w_nxt_state = ST_ADC_WAIT;
        end
      end
      ST_ADC_WAIT: begin
        if (spi_done) begin
          w_nxt_valid = 1'b1;
          w_nxt_sdata = spi_rdata;
          w_nxt_sch   = r_ptr;
          w_nxt_fair  = 1'b0;
          w_nxt_state = ST_OUTPUT;
        end else if (w_to_hit) begin
          w_nxt_err   = 1'b1;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_to = r_to_cnt + TO_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (sample_ready) begin
          w_nxt_valid = 1'b0;
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Pointer resets to the top channel so the first scan lands on the lowest set bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= CH_W'(NUM_CH - 1);
      r_cnt        <= '0;
      r_to_cnt     <= '0;
      r_fair       <= 1'b0;
      r_spi_start  <= 1'b0;
      r_spi_target <= 1'b0;
      r_spi_wdata  <= '0;
      r_dac_ack    <= 1'b0;
      r_sel        <= '0;
      r_en         <= '0;
      r_gain       <= '0;
      r_valid      <= 1'b0;
      r_sdata      <= '0;
      r_sch        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_ptr        <= w_nxt_ptr;
      r_cnt        <= w_nxt_cnt;
      r_to_cnt     <= w_nxt_to;
      r_fair       <= w_nxt_fair;
      r_spi_start  <= w_nxt_start;
      r_spi_target <= w_nxt_tgt;
      r_spi_wdata  <= w_nxt_wdata;
      r_dac_ack    <= w_nxt_ack;
      r_sel        <= w_nxt_sel;
      r_en         <= w_nxt_en;
      r_gain       <= w_nxt_gain;
      r_valid      <= w_nxt_valid;
      r_sdata      <= w_nxt_sdata;
      r_sch        <= w_nxt_sch;
      r_err        <= w_nxt_err;
    end
  end

  assign dac_ack      = r_dac_ack;
  assign spi_start    = r_spi_start;
  assign spi_target   = r_spi_target;
  assign spi_wdata    = r_spi_wdata;
  assign ni_sel_ch    = r_sel;
  assign ni_en_ch     = r_en;
  assign ni_pga_gain  = r_gain;
  assign sample_valid = r_valid;
  assign sample_data  = r_sdata;
  assign sample_ch    = r_sch;
  assign spi_err      = r_err;

endmodule

// File: tb/tb_nipcb_scan_sched.sv
// Directed and randomized bench for nipcb_scan_sched with an SPI engine responder,
// a transaction monitor and a scan-order reference model.
module tb_nipcb_scan_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  chan_mask = '0;
  logic [11:0] gain_cfg = '0;
  logic [15:0] settle_cycles = '0;
  logic        dac_req = 1'b0;
  logic [15:0] dac_data = '0;
  logic        dac_ack;
  logic        spi_start;
  logic        spi_target;
  logic [15:0] spi_wdata;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rdata = '0;
  logic [3:0]  ni_sel_ch;
  logic [3:0]  ni_en_ch;
  logic [2:0]  ni_pga_gain;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic [15:0] sample_data;
  logic [1:0]  sample_ch;
  logic        spi_err;

  always #5 clk = ~clk;

  nipcb_scan_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .gain_cfg(gain_cfg), .settle_cycles(settle_cycles),
    .dac_req(dac_req), .dac_data(dac_data), .dac_ack(dac_ack),
    .spi_start(spi_start), .spi_target(spi_target), .spi_wdata(spi_wdata),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .ni_sel_ch(ni_sel_ch), .ni_en_ch(ni_en_ch), .ni_pga_gain(ni_pga_gain),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_ch(sample_ch), .spi_err(spi_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every observable transaction at the falling edge.
  typedef struct {
    int         cyc;
    logic       tgt;
    logic [15:0] wd;
    logic [3:0] sel;
    logic [2:0] gain;
  } start_t;
  start_t      st_q[$];
  int          sel_cyc_q[$];
  logic [3:0]  sel_val_q[$];
  logic [3:0]  sel_prev = '0;
  logic [1:0]  smp_ch_q[$];
  logic [15:0] smp_dat_q[$];
  logic [15:0] rd_q[$];
  int          ack_cnt = 0;
  int          err_cyc = -1;

  always @(negedge clk) begin
    if (spi_start) st_q.push_back('{cyc, spi_target, spi_wdata, ni_sel_ch, ni_pga_gain});
    if (ni_sel_ch !== sel_prev) begin
      sel_cyc_q.push_back(cyc);
      sel_val_q.push_back(ni_sel_ch);
    end
    sel_prev = ni_sel_ch;
    if (sample_valid && sample_ready) begin
      smp_ch_q.push_back(sample_ch);
      smp_dat_q.push_back(sample_data);
    end
    if (dac_ack) ack_cnt++;
    if (spi_err && err_cyc < 0) err_cyc = cyc;
  end

  // SPI engine responder with programmable latency; can be told to never finish.
  int          eng_lat = 3;
  int          eng_cnt = 0;
  bit          eng_hang = 1'b0;
  logic [15:0] eng_next = '0;

  always @(negedge clk) begin
    spi_done = 1'b0;
    if (reset) begin
      spi_busy = 1'b0;
      eng_cnt  = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        spi_busy = 1'b0;
        if (!eng_hang) begin
          spi_done  = 1'b1;
          spi_rdata = eng_next;
        end
      end
    end else if (spi_start) begin
      spi_busy = 1'b1;
      eng_cnt  = eng_lat;
      eng_next = 16'($urandom);
      if (spi_target) rd_q.push_back(eng_next);
    end
  end

  // Sample consumer: 0 = always ready, 1 = back-pressure, 2 = random.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       sample_ready = 1'b1;
      1:       sample_ready = 1'b0;
      default: sample_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic do_reset(input int n);
    reset   = 1'b1;
    enable  = 1'b0;
    dac_req = 1'b0;
    repeat (n) @(negedge clk);
    st_q.delete(); sel_cyc_q.delete(); sel_val_q.delete();
    smp_ch_q.delete(); smp_dat_q.delete(); rd_q.delete();
    ack_cnt  = 0;
    err_cyc  = -1;
    sel_prev = '0;
    reset    = 1'b0;
  endtask

  initial begin
    int          b;
    int          s;
    int          bad;
    int          n0;
    int          p;
    int          c;
    logic [15:0] d;
    logic [1:0]  ch;
    logic [3:0]  m;
    logic [11:0] g;
    logic [15:0] dd;

    // Reset values
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_ctl", {dac_ack, spi_start, spi_target, spi_wdata, ni_sel_ch, ni_en_ch, ni_pga_gain}, '0);
    check("rst_smp", {sample_valid, sample_data, sample_ch, spi_err}, '0);
    do_reset(1);

    // Basic scan over channels 0 and 2
    eng_lat = 3; rdy_mode = 0;
    chan_mask = 4'b0101; settle_cycles = 16'd3; gain_cfg = 12'o7531;
    enable = 1'b1;
    b = 0;
    while (smp_ch_q.size() < 3 && b < 500) begin @(negedge clk); b++; end
    check("t1_wait", b < 500, 1);
    enable = 1'b0;
    if (smp_ch_q.size() >= 3 && st_q.size() >= 3 && sel_val_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        c = (i == 1) ? 2 : 0;
        check($sformatf("t1_sel%0d", i), sel_val_q[i], 4'b0001 << c);
        check($sformatf("t1_lat%0d", i), st_q[i].cyc - sel_cyc_q[i], 4);
        check($sformatf("t1_wd%0d", i), st_q[i].wd, (c == 2) ? 16'h8B00 : 16'h8300);
        check($sformatf("t1_ch%0d", i), smp_ch_q[i], c);
        check($sformatf("t1_dat%0d", i), smp_dat_q[i], rd_q[i]);
      end
    end
    check("t1_en", ni_en_ch, 4'b0101);
    do_reset(3);

    // DAC request interleaved into a running scan
    enable = 1'b1;
    b = 0;
    while (st_q.size() < 1 && b < 100) begin @(negedge clk); b++; end
    dac_req = 1'b1; dac_data = 16'hABCD;
    b = 0;
    while (!dac_ack && b < 200) begin @(negedge clk); b++; end
    dac_req = 1'b0;
    check("t2_ack_wait", b < 200, 1);
    b = 0;
    while (st_q.size() < 3 && b < 200) begin @(negedge clk); b++; end
    check("t2_wait", b < 200, 1);
    repeat (5) @(negedge clk);
    check("t2_ack_pulse", ack_cnt, 1);
    if (st_q.size() >= 3) begin
      check("t2_st0", {st_q[0].tgt, st_q[0].wd}, {1'b1, 16'h8300});
      check("t2_st1", {st_q[1].tgt, st_q[1].wd}, {1'b0, 16'hABCD});
      check("t2_st2", {st_q[2].tgt, st_q[2].wd}, {1'b1, 16'h8B00});
    end
    do_reset(3);

    // Consumer back-pressure
    rdy_mode = 1;
    enable = 1'b1;
    b = 0;
    while (!sample_valid && b < 100) begin @(negedge clk); b++; end
    check("t3_valid", sample_valid, 1);
    d = sample_data; ch = sample_ch; n0 = st_q.size();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!sample_valid || sample_data !== d || sample_ch !== ch) bad++;
    end
    check("t3_stable", bad, 0);
    check("t3_no_start", st_q.size(), n0);
    check("t3_data", d, rd_q[0]);
    rdy_mode = 0;
    b = 0;
    while (st_q.size() <= n0 && b < 100) begin @(negedge clk); b++; end
    check("t3_resume", b < 100, 1);
    if (smp_ch_q.size() >= 1) check("t3_deliv", {smp_ch_q[0], smp_dat_q[0]}, {2'd0, d});
    do_reset(3);

    // Enable dropped while the conversion is in flight
    eng_lat = 20;
    enable = 1'b1;
    b = 0;
    while (st_q.size() < 1 && b < 100) begin @(negedge clk); b++; end
    enable = 1'b0;
    repeat (60) @(negedge clk);
    check("t4_nsmp", smp_ch_q.size(), 1);
    check("t4_nstart", st_q.size(), 1);
    if (smp_ch_q.size() >= 1) check("t4_smp", {smp_ch_q[0], smp_dat_q[0]}, {2'd0, rd_q[0]});
    eng_lat = 3;
    chan_mask = 4'b0000; enable = 1'b1;
    dd = 16'($urandom);
    dac_req = 1'b1; dac_data = dd;
    b = 0;
    while (!dac_ack && b < 100) begin @(negedge clk); b++; end
    dac_req = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_ack", ack_cnt, 1);
    check("t4_nstart2", st_q.size(), 2);
    if (st_q.size() >= 2) check("t4_dac", {st_q[1].tgt, st_q[1].wd}, {1'b0, dd});
    check("t4_nsmp2", smp_ch_q.size(), 1);
    do_reset(3);

    // SPI engine hangs: timeout, then DAC still served
    eng_hang = 1'b1; eng_lat = 2;
    chan_mask = 4'b0001; settle_cycles = 16'd0; enable = 1'b1;
    b = 0;
    while (st_q.size() < 1 && b < 50) begin @(negedge clk); b++; end
    enable = 1'b0;
    s = (st_q.size() >= 1) ? st_q[0].cyc : 0;
    b = 0;
    while (err_cyc < 0 && b < 1200) begin @(negedge clk); b++; end
    check("t5_err_wait", b < 1200, 1);
    check("t5_err_cyc", err_cyc - s, 1024);
    check("t5_nsmp", smp_ch_q.size(), 0);
    check("t5_nstart", st_q.size(), 1);
    eng_hang = 1'b0;
    dac_req = 1'b1; dac_data = 16'h5A5A;
    b = 0;
    while (!dac_ack && b < 100) begin @(negedge clk); b++; end
    dac_req = 1'b0;
    check("t5_ack", b < 100, 1);
    check("t5_err_sticky", spi_err, 1);
    if (st_q.size() >= 2) check("t5_dac", {st_q[1].tgt, st_q[1].wd}, {1'b0, 16'h5A5A});
    do_reset(3);

    // Per-channel gain, all channels, zero settle
    eng_lat = 3;
    chan_mask = 4'b1111; gain_cfg = 12'o7531; settle_cycles = 16'd0;
    enable = 1'b1;
    b = 0;
    while (smp_ch_q.size() < 4 && b < 300) begin @(negedge clk); b++; end
    enable = 1'b0;
    check("t6_wait", b < 300, 1);
    if (st_q.size() >= 4 && sel_cyc_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t6_gain%0d", i), st_q[i].gain, 2 * i + 1);
        check($sformatf("t6_sel%0d", i), st_q[i].sel, 4'b0001 << i);
        check($sformatf("t6_lat%0d", i), st_q[i].cyc - sel_cyc_q[i], 1);
      end
    end
    do_reset(3);

    // Randomized scans against the scan-order model
    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      g = 12'($urandom);
      chan_mask = m; gain_cfg = g;
      settle_cycles = 16'($urandom_range(0, 4));
      eng_lat = $urandom_range(1, 6);
      rdy_mode = 2;
      enable = 1'b1;
      b = 0;
      while (smp_ch_q.size() < 6 && b < 2000) begin @(negedge clk); b++; end
      enable = 1'b0;
      check($sformatf("r%0d_wait", r), b < 2000, 1);
      p = 3;
      for (int i = 0; i < 6 && i < smp_ch_q.size() && i < st_q.size(); i++) begin
        c = -1;
        for (int k = 1; k <= 4 && c < 0; k++) if (m[(p + k) % 4]) c = (p + k) % 4;
        p = c;
        check($sformatf("r%0d_ch%0d", r, i), smp_ch_q[i], c);
        check($sformatf("r%0d_dat%0d", r, i), smp_dat_q[i], rd_q[i]);
        check($sformatf("r%0d_wd%0d", r, i), st_q[i].wd, 16'h8300 | (c << 10));
        check($sformatf("r%0d_gs%0d", r, i), {st_q[i].gain, st_q[i].sel}, {3'((g >> (3 * c)) & 7), 4'(1 << c)});
      end
      rdy_mode = 0;
      do_reset(3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
